sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_pkg.sv | 15 +
 rtl/sa_skew_line.sv | 39 +++
 rtl/sa_feeder.sv | 126 ++++++++++++
 tb/tb_sa_feeder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic array feeder and array core.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sa_pkg;

    localparam int SA_ROWS   = 8;
    localparam int SA_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Per-row delay line: DEPTH-stage data+valid shift register with synchronous clear.
// Latency: DEPTH cycles from data_i/vld_i to data_o/vld_o.
// Backpressure: none, it shifts every cycle; bubbles travel as data 0 / valid 0.
module sa_skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    // Shift one stage per cycle; reset empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q[0] <= data_i;
            vld_q[0]  <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign data_o = data_q[DEPTH-1];
    assign vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/sa_feeder.sv
// Skews operand vectors diagonally into a systolic array, one tile at a time; optional stall stats via SA_FEEDER_STATS_EN.
// Latency: lane r of a vector accepted at cycle t appears at t+1+r; tile_done at t+ROWS after the end-of-tile vector.
// Backpressure: in_ready drops for ROWS cycles while a tile drains; the skew pipeline itself never stalls.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int ROWS   = SA_ROWS,
    parameter int DATA_W = SA_DATA_W,
    parameter int TILE_K = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   in_data,
    input  logic                     in_last,
    output logic [ROWS*DATA_W-1:0]   out_data,
    output logic [ROWS-1:0]          out_valid,
    output logic                     busy,
    output logic                     tile_done,
    output logic [31:0]              bubble_cnt
);

    localparam int DRN_W = $clog2(ROWS);
    // Last DRAIN cycle, and the cycle before it (where tile_done gets registered).
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(ROWS - 1);
    localparam logic [DRN_W-1:0] DRAIN_PRE  = DRN_W'(ROWS - 2);
    localparam logic [15:0]      VEC_LAST   = 16'(TILE_K - 1);

    sa_state_e         state_q;
    logic [15:0]       vec_cnt_q;
    logic [DRN_W-1:0]  drain_cnt_q;
    logic              tile_done_q;

    logic              xfer;
    logic              eot;
    logic [ROWS*DATA_W-1:0] skew_dat;
    logic [ROWS-1:0]        skew_vld;

    assign in_ready = !rst && (state_q != DRAIN);
    assign xfer     = in_valid && in_ready;
    // The tile ends on an explicit last flag or when the vector budget is used up.
    assign eot      = in_last || (vec_cnt_q == VEC_LAST);

    // Tile sequencing: accept vectors until end-of-tile, then block input for ROWS cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                IDLE, STREAM: begin
                    if (xfer) begin
                        if (eot) begin
                            state_q     <= DRAIN;
                            vec_cnt_q   <= '0;
                            drain_cnt_q <= '0;
                        end else begin
                            state_q   <= STREAM;
                            vec_cnt_q <= vec_cnt_q + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    if (drain_cnt_q == DRAIN_PRE) begin
                        tile_done_q <= 1'b1;
                    end
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q     <= IDLE;
                        drain_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One delay line per row; row r is r+1 deep so that the vector forms a diagonal.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_W-1:0] lane_dat_d;

        assign lane_dat_d = xfer ? in_data[r*DATA_W +: DATA_W] : '0;

        sa_skew_line #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk    (clk),
            .rst    (rst),
            .data_i (lane_dat_d),
            .vld_i  (xfer),
            .data_o (skew_dat[r*DATA_W +: DATA_W]),
            .vld_o  (skew_vld[r])
        );
    end

    // Outputs read as idle for the whole cycle that reset is held, not just after it.
    assign out_data  = rst ? '0 : skew_dat;
    assign out_valid = rst ? '0 : skew_vld;
    assign busy      = !rst && (state_q != IDLE);
    assign tile_done = !rst && tile_done_q;

`ifdef SA_FEEDER_STATS_EN
    logic [31:0] bubble_q;

    // Count STREAM cycles where the producer had nothing for us; saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if ((state_q == STREAM) && !xfer && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_cnt = rst ? '0 : bubble_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder with ROWS=4, DATA_W=8, TILE_K=5.
// Latency: n/a.
// Backpressure: stimulus honours in_ready when walking the over-long tile.
module tb_sa_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        busy;
    logic        tile_done;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errs   = 0;

    sa_feeder #(
        .ROWS   (4),
        .DATA_W (8),
        .TILE_K (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .tile_done  (tile_done),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vector v: lane r carries 10*v + r.
    function automatic logic [31:0] mk(input int v);
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            res[r*8 +: 8] = 8'(10*v + r);
        end
        return res;
    endfunction

    function automatic logic [31:0] pk(input int l3, input int l2, input int l1, input int l0);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // One cycle: drive just after the edge, sample mid-cycle against hand-computed values.
    task automatic cyc(input string nm, input int n,
                       input logic r, input logic v, input logic [31:0] d, input logic l,
                       input logic [3:0] e_vld, input logic [31:0] e_dat,
                       input logic e_rdy, input logic e_busy, input logic e_done);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        #1;
        check($sformatf("%s c%0d out_valid", nm, n), 32'(out_valid), 32'(e_vld));
        check($sformatf("%s c%0d out_data", nm, n), out_data, e_dat);
        check($sformatf("%s c%0d in_ready", nm, n), 32'(in_ready), 32'(e_rdy));
        check($sformatf("%s c%0d busy", nm, n), 32'(busy), 32'(e_busy));
        check($sformatf("%s c%0d tile_done", nm, n), 32'(tile_done), 32'(e_done));
    endtask

    int          v;
    int          done_cnt;
    logic [15:0] rdy_tab;
    logic [15:0] done_tab;
    logic [31:0] exp_bubble;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(5);
        in_last  = 1'b0;

        // Reset held with a valid vector offered: everything must read idle.
        cyc("rst", 0, 1, 1, mk(5), 0, 4'b0000, 0, 0, 0, 0);
        check("rst bubble_cnt", bubble_cnt, 32'd0);
        cyc("rst", 1, 1, 1, mk(5), 1, 4'b0000, 0, 0, 0, 0);

        // Three back-to-back vectors, last on v=2.
        cyc("b2b", 0, 0, 1, mk(0), 0, 4'b0000, 0,                  1, 0, 0);
        cyc("b2b", 1, 0, 1, mk(1), 0, 4'b0001, pk(0, 0, 0, 0),     1, 1, 0);
        cyc("b2b", 2, 0, 1, mk(2), 1, 4'b0011, pk(0, 0, 1, 10),    1, 1, 0);
        cyc("b2b", 3, 0, 0, 0,     0, 4'b0111, pk(0, 2, 11, 20),   0, 1, 0);
        cyc("b2b", 4, 0, 0, 0,     0, 4'b1110, pk(3, 12, 21, 0),   0, 1, 0);
        cyc("b2b", 5, 0, 0, 0,     0, 4'b1100, pk(13, 22, 0, 0),   0, 1, 0);
        cyc("b2b", 6, 0, 0, 0,     0, 4'b1000, pk(23, 0, 0, 0),    0, 1, 1);
        cyc("b2b", 7, 0, 0, 0,     0, 4'b0000, 0,                  1, 0, 0);
        check("b2b bubble_cnt", bubble_cnt, 32'd0);

        // Transfer, one idle STREAM cycle, transfer with last: one-cycle gap per lane.
        cyc("gap", 0, 0, 1, mk(0), 0, 4'b0000, 0,                  1, 0, 0);
        cyc("gap", 1, 0, 0, mk(9), 0, 4'b0001, pk(0, 0, 0, 0),     1, 1, 0);
        cyc("gap", 2, 0, 1, mk(1), 1, 4'b0010, pk(0, 0, 1, 0),     1, 1, 0);
        cyc("gap", 3, 0, 0, 0,     0, 4'b0101, pk(0, 2, 0, 10),    0, 1, 0);
        cyc("gap", 4, 0, 0, 0,     0, 4'b1010, pk(3, 0, 11, 0),    0, 1, 0);
        cyc("gap", 5, 0, 0, 0,     0, 4'b0100, pk(0, 12, 0, 0),    0, 1, 0);
        cyc("gap", 6, 0, 0, 0,     0, 4'b1000, pk(13, 0, 0, 0),    0, 1, 1);
        cyc("gap", 7, 0, 0, 0,     0, 4'b0000, 0,                  1, 0, 0);
`ifdef SA_FEEDER_STATS_EN
        exp_bubble = 32'd1;
`else
        exp_bubble = 32'd0;
`endif
        check("gap bubble_cnt", bubble_cnt, exp_bubble);

        // Seven vectors offered, TILE_K=5 cuts the first tile; vector 6 carries last.
        rdy_tab  = 16'b1000_0110_0001_1111;
        done_tab = 16'b0100_0001_0000_0000;
        v        = 0;
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            in_valid = (v < 7);
            in_data  = mk(v);
            in_last  = (v == 6);
            #1;
            check($sformatf("tilek c%0d in_ready", k), 32'(in_ready), 32'(rdy_tab[k]));
            check($sformatf("tilek c%0d tile_done", k), 32'(tile_done), 32'(done_tab[k]));
            if (k == 8) begin
                check("tilek c8 out_valid", 32'(out_valid), 32'(4'b1000));
                check("tilek c8 out_data", out_data, pk(43, 0, 0, 0));
            end
            if (k == 10) begin
                check("tilek c10 out_valid", 32'(out_valid), 32'(4'b0001));
                check("tilek c10 out_data", out_data, pk(0, 0, 0, 50));
            end
            if (tile_done) done_cnt++;
            if (in_valid && in_ready) v++;
        end
        check("tilek vectors accepted", 32'(v), 32'd7);
        check("tilek tile_done pulses", 32'(done_cnt), 32'd2);

        // Single vector with last straight from IDLE.
        cyc("single", 0, 0, 1, mk(7), 1, 4'b0000, 0,               1, 0, 0);
        cyc("single", 1, 0, 0, 0,     0, 4'b0001, pk(0, 0, 0, 70), 0, 1, 0);
        cyc("single", 2, 0, 0, 0,     0, 4'b0010, pk(0, 0, 71, 0), 0, 1, 0);
        cyc("single", 3, 0, 0, 0,     0, 4'b0100, pk(0, 72, 0, 0), 0, 1, 0);
        cyc("single", 4, 0, 0, 0,     0, 4'b1000, pk(73, 0, 0, 0), 0, 1, 1);
        cyc("single", 5, 0, 0, 0,     0, 4'b0000, 0,               1, 0, 0);

        // Reset two cycles into DRAIN: operands dropped, no tile_done, input reopens at once.
        cyc("rstdrn", 0, 0, 1, mk(8), 1, 4'b0000, 0,               1, 0, 0);
        cyc("rstdrn", 1, 0, 0, 0,     0, 4'b0001, pk(0, 0, 0, 80), 0, 1, 0);
        cyc("rstdrn", 2, 0, 0, 0,     0, 4'b0010, pk(0, 0, 81, 0), 0, 1, 0);
        cyc("rstdrn", 3, 1, 1, mk(3), 0, 4'b0000, 0,               0, 0, 0);
        cyc("rstdrn", 4, 0, 0, 0,     0, 4'b0000, 0,               1, 0, 0);
        cyc("rstdrn", 5, 0, 1, mk(9), 0, 4'b0000, 0,               1, 0, 0);
        cyc("rstdrn", 6, 0, 0, 0,     0, 4'b0001, pk(0, 0, 0, 90), 1, 1, 0);
        cyc("rstdrn", 7, 0, 0, 0,     0, 4'b0010, pk(0, 0, 91, 0), 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
